// File: rtl/uart_rom_loader_pkg.sv
// Shared types for the UART ROM loader: session states, receiver bit phases,
// byte-order helper and the debug view of both FSMs.
package uart_rom_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_HDR_HI,
    S_HDR_LO,
    S_W_HI,
    S_W_LO,
    S_LOAD,
    S_RELEASE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_DONE
  } rx_phase_t;

  typedef struct packed {
    state_t    state;
    rx_phase_t rx_phase;
  } dbg_t;

  // The stream is big-endian: the first byte of every pair is the high byte.
  localparam int HI_SHIFT = 8;

  function automatic logic [15:0] join_be(input logic [7:0] first_byte,
                                          input logic [7:0] second_byte);
    return (16'(first_byte) << HI_SHIFT) | 16'(second_byte);
  endfunction

endpackage

// File: rtl/uart_rom_loader_if.sv
// ROM-loading handshake between the UART loader (master) and hack_soc (slave).
interface uart_rom_loader_if #(
  parameter int DATA_WIDTH = 16
);
  // 4-phase handshake: master raises rom_loader_load with rom_loader_data
  // stable; slave raises rom_loader_load_received once captured; master drops
  // load; slave drops load_received. Data only changes while both are low.
  // rom_loader_ack means the slave is ready with its write address zeroed.
  logic                  rom_loader_reset;
  logic                  rom_loader_load;
  logic [DATA_WIDTH-1:0] rom_loader_data;
  logic                  rom_loader_ack;
  logic                  rom_loader_load_received;

  modport master (
    output rom_loader_reset,
    output rom_loader_load,
    output rom_loader_data,
    input  rom_loader_ack,
    input  rom_loader_load_received
  );

  modport slave (
    input  rom_loader_reset,
    input  rom_loader_load,
    input  rom_loader_data,
    output rom_loader_ack,
    output rom_loader_load_received
  );
endinterface

// File: rtl/uart_rom_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch
// rejection on the start bit, one-cycle byte_valid / framing_err pulses.
module uart_rx_byte
  import uart_rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err,
  output rx_phase_t  phase
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

  logic        rx_meta, rx_s, rx_prev;
  rx_phase_t   phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_q, stop_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      phase_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    unique case (phase_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) phase_d = RX_START;
      end
      RX_START: begin
        // Line back high at mid start bit means the edge was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) phase_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          stop_d  = rx_s;
          phase_d = RX_DONE;
        end
      end
      RX_DONE: begin
        cnt_d   = '0;
        phase_d = RX_IDLE;
      end
      default: phase_d = RX_IDLE;
    endcase
  end

  assign byte_valid  = (phase_q == RX_DONE) &&  stop_q;
  assign framing_err = (phase_q == RX_DONE) && !stop_q;
  assign byte_data   = shift_q;
  assign phase       = phase_q;

endmodule

// File: rtl/uart_rom_loader.sv
// Receives a Hack program over UART and writes it into ROM over the 4-phase
// rom_loader handshake. Define UART_ROM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rx,
  input  logic                run,
  output logic                done_loading,
  output logic                error,
  uart_rom_loader_if.master   rl,
  output dbg_t                dbg
);

  localparam state_t END_STATE =
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    S_CSUM;
`else
    S_DONE;
`endif

  logic       byte_valid, framing_err;
  logic [7:0] byte_data;
  rx_phase_t  rx_phase;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .framing_err(framing_err),
    .phase      (rx_phase)
  );

  state_t                state_q, state_d;
  logic                  run_q;
  logic                  hold_valid_q, hold_valid_d;
  logic [7:0]            hold_data_q, hold_data_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            hi_q, hi_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  error_q, error_d;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic       run_rise, in_session, consuming, avail, take, overrun;
  logic [7:0] cur_byte;

  assign run_rise   = run && !run_q;
  assign in_session = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign consuming  = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_W_HI)   || (state_q == S_W_LO)   ||
                      (state_q == S_CSUM);
  // A byte can be consumed straight off the receiver so LOAD follows the LO byte by one cycle.
  assign avail      = hold_valid_q || byte_valid;
  assign cur_byte   = hold_valid_q ? hold_data_q : byte_data;
  assign take       = consuming && avail;
  assign overrun    = in_session && byte_valid && hold_valid_q && !take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      run_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      count_q      <= '0;
      hi_q         <= '0;
      data_q       <= '0;
      error_q      <= 1'b0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      run_q        <= run;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      count_q      <= count_d;
      hi_q         <= hi_d;
      data_q       <= data_d;
      error_q      <= error_d;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    count_d      = count_q;
    hi_d         = hi_q;
    data_d       = data_q;
    error_d      = error_q;

    // Holding register: refilled by a byte landing in the same cycle one is taken.
    if (!in_session) begin
      hold_valid_d = 1'b0;
    end else if (take) begin
      hold_valid_d = hold_valid_q && byte_valid;
      if (hold_valid_q && byte_valid) hold_data_d = byte_data;
    end else if (byte_valid) begin
      hold_valid_d = 1'b1;
      hold_data_d  = byte_data;
    end

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    csum_d = csum_q;
    if (state_q == S_IDLE)                csum_d = '0;
    else if (take && state_q != S_CSUM)   csum_d = csum_q ^ cur_byte;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          state_d = S_WAIT_ACK;
          error_d = 1'b0;
        end
      end
      S_WAIT_ACK: if (rl.rom_loader_ack) state_d = S_HDR_HI;
      S_HDR_HI: begin
        if (avail) begin
          hi_d    = cur_byte;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (avail) begin
          count_d = join_be(hi_q, cur_byte);
          state_d = (join_be(hi_q, cur_byte) == 16'd0) ? END_STATE : S_W_HI;
        end
      end
      S_W_HI: begin
        if (avail) begin
          hi_d    = cur_byte;
          state_d = S_W_LO;
        end
      end
      S_W_LO: begin
        if (avail) begin
          data_d  = DATA_WIDTH'(join_be(hi_q, cur_byte));
          state_d = S_LOAD;
        end
      end
      S_LOAD: if (rl.rom_loader_load_received) state_d = S_RELEASE;
      S_RELEASE: begin
        if (!rl.rom_loader_load_received) begin
          count_d = count_q - 16'd1;
          state_d = (count_q == 16'd1) ? END_STATE : S_W_HI;
        end
      end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      S_CSUM: if (avail) state_d = (cur_byte == csum_q) ? S_DONE : S_ERR;
`endif
      S_DONE: if (!run) state_d = S_IDLE;
      S_ERR:  if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (in_session && (framing_err || overrun)) state_d = S_ERR;
    if (state_d == S_ERR) error_d = 1'b1;
  end

  assign rl.rom_loader_reset = in_session;
  assign rl.rom_loader_load  = (state_q == S_LOAD);
  assign rl.rom_loader_data  = data_q;
  assign done_loading        = (state_q == S_DONE);
  assign error               = error_q;
  assign dbg.state           = state_q;
  assign dbg.rx_phase        = rx_phase;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: serial byte driver, hack_soc handshake model,
// strobe scoreboard against a stream-level reference, table + corner sequences.
module tb_uart_rom_loader;
  import uart_rom_loader_pkg::*;

  localparam int CPB     = 8;
  localparam int ACK_DLY = 3;

  logic clk = 1'b0;
  logic reset, uart_rx, run;
  logic done_loading, error;
  dbg_t dbg;

  uart_rom_loader_if #(.DATA_WIDTH(16)) rl ();

  uart_rom_loader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .run         (run),
    .done_loading(done_loading),
    .error       (error),
    .rl          (rl),
    .dbg         (dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int strobe_cnt = 0;
  int stab_errs  = 0;
  int lr_delay   = 2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- hack_soc model ----------------
  initial begin : hack_model
    int ack_cnt;
    int lr_cnt;
    ack_cnt = 0;
    lr_cnt  = 0;
    rl.rom_loader_ack           = 1'b0;
    rl.rom_loader_load_received = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        rl.rom_loader_ack           = 1'b0;
        rl.rom_loader_load_received = 1'b0;
        ack_cnt = 0;
        lr_cnt  = 0;
      end else begin
        if (rl.rom_loader_reset) begin
          if (ack_cnt >= ACK_DLY - 1) rl.rom_loader_ack = 1'b1;
          else ack_cnt++;
        end else begin
          rl.rom_loader_ack = 1'b0;
          ack_cnt = 0;
        end
        if (rl.rom_loader_load) begin
          if (lr_cnt >= lr_delay - 1) rl.rom_loader_load_received = 1'b1;
          else lr_cnt++;
        end else begin
          rl.rom_loader_load_received = 1'b0;
          lr_cnt = 0;
        end
      end
    end
  end

  // ---------------- strobe monitor ----------------
  logic        load_prev = 1'b0;
  logic [15:0] load_data = '0;
  always @(negedge clk) begin
    if (rl.rom_loader_load && !load_prev) begin
      got_q.push_back(rl.rom_loader_data);
      strobe_cnt++;
      load_data = rl.rom_loader_data;
    end
    if (rl.rom_loader_load && rl.rom_loader_data !== load_data) stab_errs++;
    load_prev = rl.rom_loader_load;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    if (!stop_bit) send_bit(1'b1);
    uart_rx = 1'b1;
  endtask

  task automatic start_run();
    int k;
    run = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    check("run_clears_error", error, 0);
    for (k = 0; k < 20 && !rl.rom_loader_reset; k++) @(negedge clk);
    check("session_open", rl.rom_loader_reset, 1);
    repeat (ACK_DLY + 2) @(negedge clk);
  endtask

  task automatic wait_end(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done_loading || error) break;
      @(negedge clk);
    end
    check("end_within_budget", (k < budget), 1);
  endtask

  // Reference: count from the first two bytes, then big-endian pairs; checksum is XOR of all.
  task automatic run_session(input logic [7:0] bq[$], input logic bad_csum,
                             input logic exp_err, input int exp_strobes);
    logic [7:0] csum;
    int base, count, stab_base;
    exp_q.delete();
    csum = 8'h00;
    foreach (bq[i]) csum ^= bq[i];
    count = int'({bq[0], bq[1]});
    for (int k = 0; k < count && (3 + 2 * k) < bq.size(); k++)
      exp_q.push_back({bq[2 + 2 * k], bq[3 + 2 * k]});
    start_run();
    base      = strobe_cnt;
    stab_base = stab_errs;
    foreach (bq[i]) send_byte(bq[i], 1'b1);
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (csum ^ 8'h01) : csum, 1'b1);
`else
    if (bad_csum) csum = ~csum;
`endif
    wait_end(400);
    repeat (2) @(negedge clk);
    check("done_loading", done_loading, !exp_err);
    check("error", error, exp_err);
    check("rom_loader_reset_low", rl.rom_loader_reset, 0);
    check("strobe_count", strobe_cnt - base, exp_strobes);
    for (int i = 0; i < exp_q.size(); i++)
      check("word", got_q[base + i], exp_q[i]);
    check("data_stable", stab_errs - stab_base, 0);
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("done_cleared_by_run_low", done_loading, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic [63:0] b;
    logic        exp_err;
    int          exp_strobes;
  } vec_t;

  vec_t tbl[4];

  initial begin : main
    logic [7:0] bq[$];
    int base, n, k;
    vec_t v;

    tbl[0] = '{6, 64'h0002_1234_ABCD_0000, 1'b0, 2};
    tbl[1] = '{2, 64'h0000_0000_0000_0000, 1'b0, 0};
    tbl[2] = '{4, 64'h0001_000F_0000_0000, 1'b0, 1};
    tbl[3] = '{8, 64'h0003_0102_0304_0506, 1'b0, 3};

    reset   = 1'b1;
    uart_rx = 1'b1;
    run     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", done_loading, 0);
    check("rst_error", error, 0);
    check("rst_rom_reset", rl.rom_loader_reset, 0);
    check("rst_load", rl.rom_loader_load, 0);
    check("rst_data", rl.rom_loader_data, 16'h0000);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // table-driven sessions
    for (int t = 0; t < 4; t++) begin
      v = tbl[t];
      bq.delete();
      for (int i = 0; i < v.n; i++) bq.push_back(v.b[63 - 8 * i -: 8]);
      run_session(bq, 1'b0, v.exp_err, v.exp_strobes);
    end

    // randomized programs
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      bq.delete();
      bq.push_back(8'h00);
      bq.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) bq.push_back(8'($urandom_range(0, 255)));
      run_session(bq, 1'b0, 1'b0, n);
    end

    // framing error during W_LO, then recovery with a good stream
    start_run();
    base = strobe_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    wait_end(400);
    check("frame_error", error, 1);
    check("frame_rom_reset", rl.rom_loader_reset, 0);
    check("frame_done", done_loading, 0);
    check("frame_strobes", strobe_cnt - base, 0);
    bq = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    run_session(bq, 1'b0, 1'b0, 1);

    // overrun while load_received is held off
    lr_delay = 40 * CPB;
    start_run();
    base = strobe_cnt;
    bq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    wait_end(400);
    check("ovr_error", error, 1);
    check("ovr_load_low", rl.rom_loader_load, 0);
    check("ovr_rom_reset", rl.rom_loader_reset, 0);
    check("ovr_strobes", strobe_cnt - base, 1);
    check("ovr_word", got_q[base], 16'h1122);
    run = 1'b0;
    repeat (3) @(negedge clk);
    lr_delay = 2;

    // asynchronous reset during the second LOAD
    lr_delay = 100;
    start_run();
    base = strobe_cnt;
    bq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    for (k = 0; k < 200 && !(strobe_cnt - base == 2 && rl.rom_loader_load); k++) @(negedge clk);
    check("second_load_seen", (k < 200), 1);
    #2;
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check("arst_load", rl.rom_loader_load, 0);
    check("arst_rom_reset", rl.rom_loader_reset, 0);
    check("arst_done", done_loading, 0);
    check("arst_error", error, 0);
    check("arst_data", rl.rom_loader_data, 16'h0000);
    check("arst_state", dbg.state, S_IDLE);
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    lr_delay = 2;
    repeat (2) @(negedge clk);
    run_session(bq, 1'b0, 1'b0, 2);

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    // wrong checksum byte: word still written, error raised
    bq = '{8'h00, 8'h01, 8'h00, 8'h0F};
    run_session(bq, 1'b1, 1'b1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
